// File: rtl/mul_digit_serial.sv
// ---------------------------------------------------------------------------
// mul_digit_serial
//
// Digit-serial multiplier / multiply-accumulator for the EdDSA field and
// scalar datapath. The multiplier operand b is consumed DIGIT bits per cycle,
// so the multiplier array is SIZE x DIGIT rather than SIZE x SIZE.
//
// An operation takes NDIG = ceil(SIZE/DIGIT) RUN cycles plus one FINISH
// cycle. start is sampled at edge E0, and done/result are visible after
// edge E0+NDIG+1.
//
// Ports
//   clk     : rising-edge clock
//   rst     : asynchronous reset, active low
//   start   : operation request, sampled only while idle
//   mac     : sampled with start; 1 = result += a*b, 0 = result = a*b
//   a       : multiplicand (SIZE bits), sampled with start
//   b       : multiplier (SIZE bits), sampled with start
//   result  : product or accumulated value (2*SIZE bits), registered
//   done    : one-cycle pulse, result valid
//   busy    : high from the accept cycle through the done cycle
// ---------------------------------------------------------------------------
module mul_digit_serial #(
  parameter int SIZE  = 448,
  parameter int DIGIT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mac,
  input  logic [SIZE-1:0]     a,
  input  logic [SIZE-1:0]     b,
  output logic [2*SIZE-1:0]   result,
  output logic                done,
  output logic                busy
);

  // Number of b digits; the top one is zero-padded when DIGIT does not
  // divide SIZE, and it still costs a full RUN cycle.
  localparam int NDIG = (SIZE + DIGIT - 1) / DIGIT;
  localparam int BW   = NDIG * DIGIT;
  localparam int PW   = 2 * SIZE;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PPW  = SIZE + DIGIT;

  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t            state_r;
  logic [SIZE-1:0]   a_r;
  logic [BW-1:0]     b_r;     // shifts right one digit per RUN cycle
  logic [PW-1:0]     acc_r;
  logic [KW-1:0]     k_r;

  logic [DIGIT-1:0]  digit_s;
  logic [PPW-1:0]    pp_s;
  logic [PW-1:0]     pp_ext_s;
  logic [31:0]       shamt_s;
  logic [PW-1:0]     pp_sh_s;

  // The current digit always sits at the bottom of b_r because b_r shifts.
  assign digit_s  = b_r[DIGIT-1:0];

  // SIZE x DIGIT partial product; it cannot overflow PPW bits.
  assign pp_s     = {{DIGIT{1'b0}}, a_r} * {{SIZE{1'b0}}, digit_s};

  // PPW <= PW because DIGIT <= SIZE, so the cast only zero-extends.
  assign pp_ext_s = PW'(pp_s);

  // Weight of the current digit. Bits shifted past PW are dropped, which
  // gives the modulo 2^(2*SIZE) wrap for accumulate mode at no extra cost.
  assign shamt_s  = 32'(k_r) * 32'(DIGIT);
  assign pp_sh_s  = pp_ext_s << shamt_s;

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      k_r     <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= BW'(b);
            // Accumulate mode seeds the accumulator with the previous
            // result, which is already final while idle.
            acc_r   <= mac ? result : '0;
            k_r     <= '0;
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy    <= 1'b0;
          end
        end

        ST_RUN: begin
          acc_r <= acc_r + pp_sh_s;
          b_r   <= b_r >> DIGIT;
          k_r   <= k_r + KW'(1);
          if (k_r == K_LAST) begin
            state_r <= ST_FINISH;
          end else begin
            state_r <= ST_RUN;
          end
        end

        ST_FINISH: begin
          // result only changes here, so it is stable throughout RUN.
          result  <= acc_r;
          done    <= 1'b1;
          busy    <= 1'b1;
          state_r <= ST_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_digit_serial.sv
// ---------------------------------------------------------------------------
// tb_mul_digit_serial
//
// Self-checking bench for mul_digit_serial. Three instances cover the
// configurations of interest: 16/4 (even digits), 10/4 (padded top digit)
// and the 448/64 default. Expected results come from a plain arithmetic
// reference: result = ((mac ? previous : 0) + a*b) mod 2^(2*SIZE).
// ---------------------------------------------------------------------------
module tb_mul_digit_serial;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: SIZE=16, DIGIT=4
  logic          start0 = 1'b0, mac0 = 1'b0;
  logic [15:0]   a0 = '0, b0 = '0;
  logic [31:0]   res0;
  logic          done0, busy0;

  // Instance 1: SIZE=10, DIGIT=4
  logic          start1 = 1'b0, mac1 = 1'b0;
  logic [9:0]    a1 = '0, b1 = '0;
  logic [19:0]   res1;
  logic          done1, busy1;

  // Instance 2: SIZE=448, DIGIT=64
  logic          start2 = 1'b0, mac2 = 1'b0;
  logic [447:0]  a2 = '0, b2 = '0;
  logic [895:0]  res2;
  logic          done2, busy2;

  mul_digit_serial #(.SIZE(16), .DIGIT(4)) u_m16 (
    .clk(clk), .rst(rst), .start(start0), .mac(mac0), .a(a0), .b(b0),
    .result(res0), .done(done0), .busy(busy0));

  mul_digit_serial #(.SIZE(10), .DIGIT(4)) u_m10 (
    .clk(clk), .rst(rst), .start(start1), .mac(mac1), .a(a1), .b(b1),
    .result(res1), .done(done1), .busy(busy1));

  mul_digit_serial #(.SIZE(448), .DIGIT(64)) u_m448 (
    .clk(clk), .rst(rst), .start(start2), .mac(mac2), .a(a2), .b(b2),
    .result(res2), .done(done2), .busy(busy2));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: last result of each instance.
  logic [895:0] model_res [3];

  function automatic int size_of(int sel);
    case (sel)
      0: return 16;
      1: return 10;
      default: return 448;
    endcase
  endfunction

  function automatic int lat_of(int sel);
    int s, d;
    s = size_of(sel);
    d = (sel == 2) ? 64 : 4;
    return (s + d - 1) / d + 1;
  endfunction

  function automatic logic get_done(int sel);
    case (sel)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_busy(int sel);
    case (sel)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic [895:0] get_res(int sel);
    case (sel)
      0: return 896'(res0);
      1: return 896'(res1);
      default: return res2;
    endcase
  endfunction

  function automatic logic [895:0] ref_mul(int sel, logic [447:0] a,
                                           logic [447:0] b, logic mac,
                                           logic [895:0] prev);
    logic [896:0] t;
    logic [896:0] m;
    t = 897'(a) * 897'(b);
    if (mac) t = t + 897'(prev);
    m = (897'(1) << (2 * size_of(sel))) - 897'(1);
    return 896'(t & m);
  endfunction

  task automatic drive(int sel, logic [447:0] a, logic [447:0] b,
                       logic mac, logic st);
    case (sel)
      0: begin a0 = a[15:0]; b0 = b[15:0]; mac0 = mac; start0 = st; end
      1: begin a1 = a[9:0];  b1 = b[9:0];  mac1 = mac; start1 = st; end
      default: begin a2 = a; b2 = b; mac2 = mac; start2 = st; end
    endcase
  endtask

  // Run one operation and check latency, busy window, result hold during
  // RUN and the final value against the reference model.
  task automatic do_op(input int sel, input logic [447:0] a_in,
                       input logic [447:0] b_in, input logic mac,
                       input bit chk_idle, output logic [895:0] got);
    logic [447:0] msk, am, bm;
    logic [895:0] exp_v, prev;
    int cyc, hi, lat;
    bit held;
    msk   = (448'(1) << size_of(sel)) - 448'(1);
    if (sel == 2) msk = '1;
    am    = a_in & msk;
    bm    = b_in & msk;
    prev  = model_res[sel];
    exp_v = ref_mul(sel, am, bm, mac, prev);
    lat   = lat_of(sel);
    got   = '0;

    drive(sel, am, bm, mac, 1'b1);
    @(posedge clk); #1;
    drive(sel, ~am, ~bm, ~mac, 1'b0);   // scramble inputs during RUN

    cyc = 0; hi = 0; held = 1'b1;
    while (!get_done(sel) && cyc < 60) begin
      if (get_busy(sel)) hi++;
      if (get_res(sel) !== prev) held = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end

    n_cmp++;
    if (!get_done(sel)) begin
      n_bad++;
      $display("FAIL done_timeout[%0d]: no done within %0d cycles", sel, cyc);
      return;
    end
    got = get_res(sel);

    n_cmp++;
    if (cyc !== lat) begin
      n_bad++;
      $display("FAIL latency[%0d]: got %0d want %0d", sel, cyc, lat);
    end
    n_cmp++;
    if (hi !== lat || get_busy(sel) !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_window[%0d]: got %0d+%0b want %0d+1", sel, hi,
               get_busy(sel), lat);
    end
    n_cmp++;
    if (!held) begin
      n_bad++;
      $display("FAIL result_hold[%0d]: result changed before done", sel);
    end
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL result[%0d]: got %0h want %0h", sel, got, exp_v);
    end
    model_res[sel] = exp_v;

    if (chk_idle) begin
      @(posedge clk); #1;
      n_cmp++;
      if (get_done(sel) !== 1'b0 || get_busy(sel) !== 1'b0) begin
        n_bad++;
        $display("FAIL after_done[%0d]: done=%0b busy=%0b want 0 0", sel,
                 get_done(sel), get_busy(sel));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (get_res(s) !== '0 || get_done(s) !== 1'b0 || get_busy(s) !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: res=%0h done=%0b busy=%0b want 0 0 0",
                 s, get_res(s), get_done(s), get_busy(s));
      end
      model_res[s] = '0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plan_16;
    logic [895:0] got;
    do_op(0, 448'hFFFF, 448'hFFFF, 1'b0, 1'b0, got);
    n_cmp++;
    if (got !== 896'hFFFE0001) begin
      n_bad++; $display("FAIL plan16_mul: got %0h want fffe0001", got);
    end
    do_op(0, 448'hFFFF, 448'hFFFF, 1'b1, 1'b0, got);   // back to back
    n_cmp++;
    if (got !== 896'hFFFC0002) begin
      n_bad++; $display("FAIL plan16_mac_wrap: got %0h want fffc0002", got);
    end
    do_op(0, 448'd2, 448'd3, 1'b1, 1'b1, got);
    n_cmp++;
    if (got !== 896'hFFFC0008) begin
      n_bad++; $display("FAIL plan16_mac: got %0h want fffc0008", got);
    end
  endtask

  task automatic test_padded_10;
    logic [895:0] got;
    do_op(1, 448'h3FF, 448'h3FF, 1'b0, 1'b1, got);
    n_cmp++;
    if (got !== 896'hFF801) begin
      n_bad++; $display("FAIL pad10_max: got %0h want ff801", got);
    end
    do_op(1, 448'h0, 448'h3FF, 1'b0, 1'b1, got);
    n_cmp++;
    if (got !== 896'h0) begin
      n_bad++; $display("FAIL pad10_zero: got %0h want 0", got);
    end
  endtask

  task automatic test_ignore_start;
    logic [895:0] got, seen;
    int dones, when_c;
    @(negedge clk);
    drive(0, 448'd3, 448'd5, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 448'd3, 448'd5, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 448'd7, 448'd7, 1'b0, 1'b1);              // while busy
    @(posedge clk); #1;
    drive(0, 448'd7, 448'd7, 1'b0, 1'b0);
    dones = 0; when_c = 0; seen = '0;
    for (int c = 3; c <= 14; c++) begin
      if (done0) begin dones++; when_c = c - 1; seen = 896'(res0); end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (dones !== 1 || seen !== 896'hF || when_c !== 5) begin
      n_bad++;
      $display("FAIL ignore_start: dones=%0d res=%0h at=%0d want 1 f 5",
               dones, seen, when_c);
    end
    model_res[0] = 896'hF;
    do_op(0, 448'd7, 448'd7, 1'b0, 1'b1, got);
    n_cmp++;
    if (got !== 896'h31) begin
      n_bad++; $display("FAIL start_after_ignore: got %0h want 31", got);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [895:0] got;
    int dones;
    @(negedge clk);
    drive(0, 448'h1234, 448'h5678, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 448'h1234, 448'h5678, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (res0 !== 32'h0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: res=%0h done=%0b busy=%0b want 0 0 0",
               res0, done0, busy0);
    end
    for (int s = 0; s < 3; s++) model_res[s] = '0;
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done0 || busy0) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++; $display("FAIL no_done_after_reset: got %0d active cycles want 0", dones);
    end
    do_op(0, 448'h1234, 448'h5678, 1'b1, 1'b1, got);
    n_cmp++;
    if (got !== 896'h06260060) begin
      n_bad++; $display("FAIL mac_after_reset: got %0h want 6260060", got);
    end
  endtask

  task automatic test_defaults_448;
    logic [895:0] got, want;
    logic [447:0] ones;
    ones = '1;
    do_op(2, ones, 448'd2, 1'b0, 1'b1, got);
    want = (896'(1) << 449) - 896'd2;
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL def448_x2: got %0h want %0h", got, want);
    end
    do_op(2, ones, ones, 1'b0, 1'b1, got);
    want = (896'(0) - (896'(1) << 449)) + 896'd1;      // 2^896 - 2^449 + 1
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL def448_max: got %0h want %0h", got, want);
    end
  endtask

  task automatic test_random;
    logic [895:0] got;
    logic [447:0] ra, rb;
    int sel;
    for (int i = 0; i < 40; i++) begin
      sel = (i % 5 == 4) ? 2 : (i % 2);
      for (int w = 0; w < 14; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      case ($urandom_range(0, 5))
        0: ra = '1;
        1: rb = '0;
        2: begin ra = '1; rb = '1; end
        default: ;
      endcase
      do_op(sel, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
    end
  endtask

  initial begin
    test_reset();
    test_plan_16();
    test_padded_10();
    test_ignore_start();
    test_reset_mid_op();
    test_defaults_448();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
